f2h_avmm_engine: RTL and testbench
==================================

# f2h_avmm_engine

Transaction engine between the F2H tester CSR block and the FPGA-to-HPS bridge. It accepts single-cycle read and write request pulses with an address and write data, and issues one Avalon-MM master transaction per request on the F2H bridge, adapting to a wider bridge data path. It returns the read data, a completion pulse and the measured read latency in cycles. An optional timeout recovers from bridge hangs.

## Interface
- DATA_WIDTH, 32: request/response data width.
- F2H_DATA_WIDTH, 128: bridge data width; power of two, multiple of DATA_WIDTH.
- F2H_ADDR_WIDTH, 32: bridge byte-address width.
- TIMEOUT_CYCLES, 1024: timeout threshold; used only with F2H_TIMEOUT_EN.
- clk  in  1  sole clock.
- rstn  in  1  reset, asynchronous assert, active-low.
- write  in  1  write request pulse (one cycle).
- read  in  1  read request pulse (one cycle).
- address  in  DATA_WIDTH  byte address, DATA_WIDTH-aligned.
- write_data  in  DATA_WIDTH  write payload.
- read_data  out  DATA_WIDTH  last read result.
- read_data_valid  out  1  one-cycle read-completion pulse.
- read_latency  out  32  latency of the last completed read.
- busy  out  1  high whenever the FSM is not in IDLE.
- timeout  out  1  sticky flag: the last transaction timed out.
- avm_address  out  F2H_ADDR_WIDTH  bridge address, F2H_DATA_WIDTH-aligned.
- avm_read, avm_write  out  1  bridge commands.
- avm_writedata  out  F2H_DATA_WIDTH  bridge write data.
- avm_byteenable  out  F2H_DATA_WIDTH/8  lane byte enables.
- avm_waitrequest  in  1  bridge stall.
- avm_readdata  in  F2H_DATA_WIDTH  bridge read data.
- avm_readdatavalid  in  1  bridge read response.

## Operation
- FSM states:
  - IDLE: waits for a request.
  - WR_CMD: holds avm_write.
  - RD_CMD: holds avm_read.
  - RD_WAIT: waits for avm_readdatavalid.
- IDLE transitions:
  - write -> WR_CMD.
  - read -> RD_CMD.
  - Both asserted in the same cycle: write wins and the read is dropped.
- Requests arriving outside IDLE are dropped; busy tells the requester when it may issue.
- Address and data are latched on request acceptance.
  - avm_address = address with the low log2(F2H_DATA_WIDTH/8) bits cleared.
  - Lane index = address[log2(F2H_DATA_WIDTH/8)-1 : log2(DATA_WIDTH/8)].
- Writes:
  - avm_writedata = write_data replicated across all lanes.
  - avm_byteenable = all ones on the selected lane only.
  - Reads use all-ones byte enables.
- WR_CMD -> IDLE on the first cycle with avm_waitrequest low.
- RD_CMD -> RD_WAIT on the first cycle with avm_waitrequest low.
- RD_WAIT: avm_readdatavalid captures the selected lane into read_data and returns to IDLE.
- avm_readdatavalid is ignored in any state other than RD_WAIT.
- Latency counter:
  - Cleared to 0 in the cycle avm_read first asserts; increments every cycle while in RD_CMD or RD_WAIT.
  - Its value is captured into read_latency in the avm_readdatavalid cycle.
  - Saturates at 32'hFFFF_FFFF.
- timeout is cleared by the next accepted request.

## Timing
- Reset values: avm_read, avm_write, read_data_valid, busy, timeout = 0; read_data, read_latency, avm_address, avm_writedata, avm_byteenable = 0; FSM = IDLE.
- Reset asserted mid-transaction aborts immediately with no completion pulse.
- Request pulse in cycle N -> avm_read/avm_write high in cycle N+1 (registered); busy high from N+1.
- avm_readdatavalid in cycle M -> read_data, read_latency and the read_data_valid pulse all appear in M+1; busy low in M+1.
- A write completes with busy low in the cycle after waitrequest-low acceptance; writes produce no response pulse.
- Latency example: accepted in the first command cycle, data the next cycle -> read_latency = 1.

## Configuration
- F2H_TIMEOUT_EN defined:
  - The FSM aborts when the counter reaches TIMEOUT_CYCLES in WR_CMD, RD_CMD or RD_WAIT.
  - On abort: deassert the command and return to IDLE with timeout = 1.
  - Reads additionally return read_data = F2H_TIMEOUT_DATA, read_latency = TIMEOUT_CYCLES and a read_data_valid pulse.
  - The counter also runs in WR_CMD.
  - Abort deliberately breaks Avalon command hold; this is tester-only behaviour.
- F2H_TIMEOUT_EN undefined: no timeout; the FSM waits indefinitely and timeout is tied to 0.

## Structure
- Package f2h_pkg holds the state enum f2h_state_e and F2H_TIMEOUT_DATA = 32'hDEAD_BEEF.
- Sub-module f2h_lane_mux performs lane selection: write replication, byte-enable generation and read lane extraction.

## Test plan
- Write to 0x1004 = 0xA5A5_5A5A with 3 waitrequest cycles -> avm_write held 4 cycles, avm_address 0x1000, byteenable 0x00F0, lane 1 = 0xA5A5_5A5A.
- Read from 0x200C with immediate accept and data 5 cycles later -> read_data = lane 3, read_latency = 5, one read_data_valid pulse.
- Read and write pulses in the same cycle -> only the write is issued; a read pulse while busy is ignored.
- Spurious avm_readdatavalid in IDLE -> no read_data change and no pulse.
- With F2H_TIMEOUT_EN and TIMEOUT_CYCLES = 16, read with no response -> pulse, data 0xDEAD_BEEF, latency 16, timeout = 1; the next request clears timeout.
- rstn dropped during RD_WAIT -> all outputs return to reset values immediately and no pulse follows.

Source files
------------

// File: rtl/f2h_pkg.sv
// Shared types and constants for the F2H Avalon-MM transaction engine.
package f2h_pkg;

   typedef enum logic [1:0] {
      F2H_IDLE    = 2'd0,
      F2H_WR_CMD  = 2'd1,
      F2H_RD_CMD  = 2'd2,
      F2H_RD_WAIT = 2'd3
   } f2h_state_e;

   localparam logic [31:0] F2H_TIMEOUT_DATA = 32'hDEAD_BEEF;

   // Width of a lane index; kept at least one bit so a single-lane bridge still elaborates.
   function automatic int lane_bits(input int lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

endpackage

// File: rtl/f2h_lane_mux.sv
// Lane adaptation between the narrow request path and the wide F2H bridge data path.
module f2h_lane_mux
   import f2h_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int F2H_DATA_WIDTH = 128
) (
   input  logic [lane_bits(F2H_DATA_WIDTH/DATA_WIDTH)-1:0] lane,
   input  logic [DATA_WIDTH-1:0]                           write_data,
   input  logic [F2H_DATA_WIDTH-1:0]                       wide_read_data,
   output logic [F2H_DATA_WIDTH-1:0]                       wide_write_data,
   output logic [F2H_DATA_WIDTH/8-1:0]                     byteenable,
   output logic [DATA_WIDTH-1:0]                           lane_read_data
);

   localparam int LANES = F2H_DATA_WIDTH / DATA_WIDTH;
   localparam int BPL   = DATA_WIDTH / 8;

   assign wide_write_data = {LANES{write_data}};

   always_comb begin
      // NOTE: every output gets a default before the indexed write, otherwise a latch is inferred.
      byteenable                   = '0;
      byteenable[lane*BPL +: BPL]  = '1;
      lane_read_data               = wide_read_data[lane*DATA_WIDTH +: DATA_WIDTH];
   end

endmodule

// File: rtl/f2h_avmm_engine.sv
// Single-transaction Avalon-MM master for the F2H bridge; optional timeout recovery
// is compiled in with the F2H_TIMEOUT_EN macro.
module f2h_avmm_engine
   import f2h_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int F2H_DATA_WIDTH = 128,
   parameter int F2H_ADDR_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          write,
   input  logic                          read,
   input  logic [DATA_WIDTH-1:0]         address,
   input  logic [DATA_WIDTH-1:0]         write_data,
   output logic [DATA_WIDTH-1:0]         read_data,
   output logic                          read_data_valid,
   output logic [31:0]                   read_latency,
   output logic                          busy,
   output logic                          timeout,
   output logic [F2H_ADDR_WIDTH-1:0]     avm_address,
   output logic                          avm_read,
   output logic                          avm_write,
   output logic [F2H_DATA_WIDTH-1:0]     avm_writedata,
   output logic [F2H_DATA_WIDTH/8-1:0]   avm_byteenable,
   input  logic                          avm_waitrequest,
   input  logic [F2H_DATA_WIDTH-1:0]     avm_readdata,
   input  logic                          avm_readdatavalid
);

   localparam int LANES    = F2H_DATA_WIDTH / DATA_WIDTH;
   localparam int LANE_W   = lane_bits(LANES);
   localparam int SUB_BITS = $clog2(DATA_WIDTH / 8);
   localparam int BUS_BITS = $clog2(F2H_DATA_WIDTH / 8);
   localparam logic [F2H_ADDR_WIDTH-1:0] ADDR_MASK =
      ~((F2H_ADDR_WIDTH'(1) << BUS_BITS) - F2H_ADDR_WIDTH'(1));
   localparam logic [31:0] CNT_MAX       = '1;
   localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

   f2h_state_e                  state;
   logic [LANE_W-1:0]           lane_req;
   logic [LANE_W-1:0]           lane_q;
   logic [LANE_W-1:0]           lane_sel;
   logic [31:0]                 cnt;
   logic [31:0]                 cnt_inc;
   logic                        expired;
   logic [F2H_DATA_WIDTH-1:0]   wr_rep;
   logic [F2H_DATA_WIDTH/8-1:0] wr_be;
   logic [DATA_WIDTH-1:0]       rd_lane;

   assign lane_req  = LANE_W'((address >> SUB_BITS) & DATA_WIDTH'(LANES - 1));
   // The mux serves the incoming request while idle and the latched lane afterwards.
   assign lane_sel  = (state == F2H_IDLE) ? lane_req : lane_q;
   assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 32'd1;

   assign busy      = (state != F2H_IDLE);
   assign avm_write = (state == F2H_WR_CMD);
   assign avm_read  = (state == F2H_RD_CMD);

`ifdef F2H_TIMEOUT_EN
   assign expired = (cnt == TIMEOUT_LIMIT);
`else
   assign expired = 1'b0;
`endif

   f2h_lane_mux #(
      .DATA_WIDTH     (DATA_WIDTH),
      .F2H_DATA_WIDTH (F2H_DATA_WIDTH)
   ) u_lane_mux (
      .lane            (lane_sel),
      .write_data      (write_data),
      .wide_read_data  (avm_readdata),
      .wide_write_data (wr_rep),
      .byteenable      (wr_be),
      .lane_read_data  (rd_lane)
   );

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state           <= F2H_IDLE;
         lane_q          <= '0;
         cnt             <= '0;
         read_data       <= '0;
         read_data_valid <= 1'b0;
         read_latency    <= '0;
         timeout         <= 1'b0;
         avm_address     <= '0;
         avm_writedata   <= '0;
         avm_byteenable  <= '0;
      end else begin
         read_data_valid <= 1'b0;
         case (state)
            F2H_IDLE: begin
               if (write || read) begin
                  lane_q      <= lane_req;
                  cnt         <= '0;
                  timeout     <= 1'b0;
                  avm_address <= F2H_ADDR_WIDTH'(address) & ADDR_MASK;
                  if (write) begin
                     state          <= F2H_WR_CMD;
                     avm_writedata  <= wr_rep;
                     avm_byteenable <= wr_be;
                  end else begin
                     state          <= F2H_RD_CMD;
                     avm_byteenable <= '1;
                  end
               end
            end
            F2H_WR_CMD: begin
               cnt <= cnt_inc;
               if (!avm_waitrequest) begin
                  state <= F2H_IDLE;
               end else if (expired) begin
                  state   <= F2H_IDLE;
                  timeout <= 1'b1;
               end
            end
            F2H_RD_CMD: begin
               cnt <= cnt_inc;
               if (!avm_waitrequest) begin
                  state <= F2H_RD_WAIT;
               end else if (expired) begin
                  state           <= F2H_IDLE;
                  timeout         <= 1'b1;
                  read_data       <= DATA_WIDTH'(F2H_TIMEOUT_DATA);
                  read_latency    <= TIMEOUT_LIMIT;
                  read_data_valid <= 1'b1;
               end
            end
            F2H_RD_WAIT: begin
               cnt <= cnt_inc;
               if (avm_readdatavalid) begin
                  state           <= F2H_IDLE;
                  read_data       <= rd_lane;
                  read_latency    <= cnt;
                  read_data_valid <= 1'b1;
               end else if (expired) begin
                  state           <= F2H_IDLE;
                  timeout         <= 1'b1;
                  read_data       <= DATA_WIDTH'(F2H_TIMEOUT_DATA);
                  read_latency    <= TIMEOUT_LIMIT;
                  read_data_valid <= 1'b1;
               end
            end
            default: state <= F2H_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_f2h_avmm_engine.sv
// Scoreboard bench for f2h_avmm_engine; the timeout scenario runs when F2H_TIMEOUT_EN is defined.
module tb_f2h_avmm_engine;

   localparam int DW = 32;
   localparam int FW = 128;
   localparam int AW = 32;
   localparam int TO = 16;

   logic           clk = 1'b0;
   logic           rstn;
   logic           write, read;
   logic [DW-1:0]  address, write_data;
   logic [DW-1:0]  read_data;
   logic           read_data_valid;
   logic [31:0]    read_latency;
   logic           busy, timeout;
   logic [AW-1:0]  avm_address;
   logic           avm_read, avm_write;
   logic [FW-1:0]  avm_writedata;
   logic [FW/8-1:0] avm_byteenable;
   logic           avm_waitrequest;
   logic [FW-1:0]  avm_readdata;
   logic           avm_readdatavalid;

   typedef struct {
      logic [31:0]  addr;
      logic [127:0] data;
      logic [15:0]  be;
      int           hold;
   } wr_exp_t;

   typedef struct {
      logic [31:0] data;
      logic [31:0] lat;
      logic        to;
   } rd_exp_t;

   wr_exp_t     wr_q[$];
   rd_exp_t     rd_q[$];
   logic [31:0] rdcmd_q[$];
   wr_exp_t     we;
   rd_exp_t     re;
   logic [31:0] ra;
   logic [31:0] last_rd;
   int          wr_hold;
   int          total = 0;
   int          bad   = 0;

   f2h_avmm_engine #(
      .DATA_WIDTH     (DW),
      .F2H_DATA_WIDTH (FW),
      .F2H_ADDR_WIDTH (AW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk               (clk),
      .rstn              (rstn),
      .write             (write),
      .read              (read),
      .address           (address),
      .write_data        (write_data),
      .read_data         (read_data),
      .read_data_valid   (read_data_valid),
      .read_latency      (read_latency),
      .busy              (busy),
      .timeout           (timeout),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_write         (avm_write),
      .avm_writedata     (avm_writedata),
      .avm_byteenable    (avm_byteenable),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bridge-side monitor: compares every accepted command and every completion pulse.
   always @(negedge clk) begin
      if (!rstn) begin
         wr_hold = 0;
      end else begin
         if (avm_write) begin
            wr_hold++;
            if (!avm_waitrequest) begin
               check("wr_expected", wr_q.size() != 0, 1'b1);
               if (wr_q.size() != 0) begin
                  we = wr_q.pop_front();
                  check("wr_addr", avm_address, we.addr);
                  check("wr_data", avm_writedata, we.data);
                  check("wr_be", avm_byteenable, we.be);
                  check("wr_hold", wr_hold, we.hold);
               end
               wr_hold = 0;
            end
         end
         if (avm_read && !avm_waitrequest) begin
            check("rdcmd_expected", rdcmd_q.size() != 0, 1'b1);
            if (rdcmd_q.size() != 0) begin
               ra = rdcmd_q.pop_front();
               check("rd_addr", avm_address, ra);
               check("rd_be", avm_byteenable, 16'hFFFF);
            end
         end
         if (read_data_valid) begin
            check("rdv_expected", rd_q.size() != 0, 1'b1);
            if (rd_q.size() != 0) begin
               re = rd_q.pop_front();
               check("rd_data", read_data, re.data);
               check("rd_latency", read_latency, re.lat);
               check("rd_timeout", timeout, re.to);
            end
         end
      end
   end

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int waits,
                           input bit with_read, input bit read_busy);
      wr_exp_t e;
      tick();
      write      = 1'b1;
      read       = with_read;
      address    = a;
      write_data = d;
      e.addr = a & 32'hFFFF_FFF0;
      e.data = {d, d, d, d};
      e.be   = 16'h000F << (4 * ((a >> 2) & 32'd3));
      e.hold = waits + 1;
      wr_q.push_back(e);
      tick();
      write = 1'b0;
      read  = read_busy;
      for (int c = 0; c <= waits; c++) begin
         avm_waitrequest = (c < waits);
         tick();
         read = 1'b0;
      end
      avm_waitrequest = 1'b0;
      check("wr_busy_done", busy, 1'b0);
      check("wr_no_pulse", read_data_valid, 1'b0);
   endtask

   task automatic do_read(input logic [31:0] a, input int waits, input int gap,
                          input logic [127:0] wide);
      rd_exp_t e;
      int      ln;
      tick();
      read    = 1'b1;
      address = a;
      ln      = int'((a >> 2) & 32'd3);
      e.data  = wide[ln*32 +: 32];
      e.lat   = 32'(gap);
      e.to    = 1'b0;
      rd_q.push_back(e);
      rdcmd_q.push_back(a & 32'hFFFF_FFF0);
      last_rd = e.data;
      tick();
      read = 1'b0;
      for (int c = 0; c <= gap; c++) begin
         avm_waitrequest   = (c < waits);
         avm_readdatavalid = (c == gap);
         avm_readdata      = (c == gap) ? wide : {$urandom, $urandom, $urandom, $urandom};
         tick();
      end
      avm_readdatavalid = 1'b0;
      avm_waitrequest   = 1'b0;
      check("rd_busy_done", busy, 1'b0);
      check("rd_pulse", read_data_valid, 1'b1);
      tick();
      check("rd_pulse_end", read_data_valid, 1'b0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_avm_read"}, avm_read, 1'b0);
      check({tag, "_avm_write"}, avm_write, 1'b0);
      check({tag, "_rdv"}, read_data_valid, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_timeout"}, timeout, 1'b0);
      check({tag, "_read_data"}, read_data, 32'h0);
      check({tag, "_latency"}, read_latency, 32'h0);
      check({tag, "_avm_address"}, avm_address, 32'h0);
      check({tag, "_avm_wdata"}, avm_writedata, 128'h0);
      check({tag, "_avm_be"}, avm_byteenable, 16'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      rstn              = 1'b0;
      write             = 1'b0;
      read              = 1'b0;
      address           = '0;
      write_data        = '0;
      avm_waitrequest   = 1'b0;
      avm_readdata      = '0;
      avm_readdatavalid = 1'b0;
      last_rd           = '0;
      repeat (3) tick();
      check_reset_values("reset");
      rstn = 1'b1;

      do_write(32'h0000_1004, 32'hA5A5_5A5A, 3, 1'b0, 1'b0);
      do_read(32'h0000_200C, 0, 5,
              {32'h3333_CCCC, 32'h2222_DDDD, 32'h1111_EEEE, 32'h0000_FFFF});
      do_read(32'h0000_3000, 2, 4,
              {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000});
      do_read(32'h0000_4008, 0, 1,
              {32'h4444_0003, 32'h4444_0002, 32'h4444_0001, 32'h4444_0000});
      do_write(32'h0000_5008, 32'h1234_5678, 0, 1'b1, 1'b0);
      do_write(32'h0000_600C, 32'hCAFE_F00D, 2, 1'b0, 1'b1);

      // Response with no outstanding read must be ignored.
      tick();
      avm_readdatavalid = 1'b1;
      avm_readdata      = {$urandom, $urandom, $urandom, $urandom};
      tick();
      avm_readdatavalid = 1'b0;
      check("spurious_no_pulse", read_data_valid, 1'b0);
      tick();
      check("spurious_data", read_data, last_rd);
      check("spurious_busy", busy, 1'b0);

`ifdef F2H_TIMEOUT_EN
      tick();
      read    = 1'b1;
      address = 32'h0000_9000;
      rd_q.push_back('{data: 32'hDEAD_BEEF, lat: 32'(TO), to: 1'b1});
      rdcmd_q.push_back(32'h0000_9000);
      last_rd = 32'hDEAD_BEEF;
      tick();
      read = 1'b0;
      avm_waitrequest = 1'b0;
      n = 0;
      while (!read_data_valid && n < 40) begin
         tick();
         n++;
      end
      check("to_pulse_seen", read_data_valid, 1'b1);
      check("to_cycles", n, TO + 1);
      tick();
      check("to_sticky", timeout, 1'b1);
      check("to_idle", busy, 1'b0);
      do_write(32'h0000_A000, 32'h0BAD_CAFE, 1, 1'b0, 1'b0);
      check("to_cleared", timeout, 1'b0);
`endif

      // Reset while waiting for read data aborts without a completion.
      tick();
      read    = 1'b1;
      address = 32'h0000_7004;
      rdcmd_q.push_back(32'h0000_7000);
      tick();
      read = 1'b0;
      avm_waitrequest = 1'b0;
      tick();
      tick();
      check("rst_pre_busy", busy, 1'b1);
      rstn = 1'b0;
      #1;
      check_reset_values("midrst");
      avm_readdatavalid = 1'b1;
      avm_readdata      = {$urandom, $urandom, $urandom, $urandom};
      tick();
      tick();
      avm_readdatavalid = 1'b0;
      rstn = 1'b1;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (read_data_valid) n++;
      end
      check("rst_no_pulse", n, 0);
      check("rst_idle", busy, 1'b0);

      do_read(32'h0000_800C, 1, 3,
              {32'h8888_0003, 32'h8888_0002, 32'h8888_0001, 32'h8888_0000});

      repeat (2) tick();
      check("wr_q_empty", wr_q.size(), 0);
      check("rd_q_empty", rd_q.size(), 0);
      check("rdcmd_q_empty", rdcmd_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
